// File: rtl/imem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_pkg : shared types and constants for the instruction-fetch slice
// Revision : 1.0
// ----------------------------------------------------------------------------
package imem_pkg;

  localparam int          IMEM_ADDR_WIDTH = 8;
  localparam int          IMEM_DATA_WIDTH = 32;
  localparam logic [31:0] IMEM_RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] NOP             = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fetch_fifo : synchronous skid FIFO of fetch_entry_t with clear (clear wins)
// Revision   : 1.0
// ----------------------------------------------------------------------------
module fetch_fifo
  import imem_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic          empty,
  output fetch_entry_t  head
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full;
  logic          do_push;
  logic          do_pop;

  always_comb begin
    full     = (count_q == CW'(DEPTH));
    empty    = (count_q == '0);
    do_push  = push & ~full;
    do_pop   = pop & ~empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // The upstream credit scheme must make overflow impossible.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule
`default_nettype wire

// File: rtl/imem_fetch.sv
`default_nettype none
// ----------------------------------------------------------------------------
// imem_fetch : PC/credit/squash logic driving a 1-cycle-latency SRAM into a
//              skid FIFO. Optional SRAM write port under macro IMEM_LOAD_EN.
// Revision   : 1.0
// ----------------------------------------------------------------------------
module imem_fetch
  import imem_pkg::*;
#(
  parameter int          ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = IMEM_DATA_WIDTH,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = IMEM_RESET_PC
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch_en,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [DATA_WIDTH-1:0] inst,
  output logic [31:0]           inst_pc,
`ifdef IMEM_LOAD_EN
  input  logic                  load_valid,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  load_ready,
`endif
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] din0,
  input  logic [DATA_WIDTH-1:0] dout0
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]     pc_q, pc_d;
  logic [31:0]     tag_q, tag_d;
  logic            inflight_q, inflight_d;
  logic [CW-1:0]   count;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    push_data;
  logic            pop;
  logic            push;
  logic            issue;
  logic [CW:0]     credits_used;
  logic [ADDR_WIDTH-1:0] rd_addr;

  always_comb begin
    pop          = ~empty & inst_ready;
    credits_used = {1'b0, count} + (CW+1)'(inflight_q) - (CW+1)'(pop);
    // rst_n gating keeps the SRAM deselected for the whole reset window.
    issue        = rst_n & fetch_en & ~redirect_valid &
                   (credits_used < (CW+1)'(FIFO_DEPTH));
    push         = inflight_q & ~redirect_valid;
    push_data    = '{pc: tag_q, inst: 32'(dout0)};
    rd_addr      = rst_n ? pc_q[ADDR_WIDTH+1:2] : '0;
    pc_d         = pc_q;
    tag_d        = tag_q;
    inflight_d   = issue;
    if (redirect_valid) begin
      pc_d = redirect_pc & ~32'h3;
    end else if (issue) begin
      tag_d = pc_q;
      pc_d  = next_pc(pc_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      tag_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      inflight_q <= inflight_d;
    end
  end

`ifdef IMEM_LOAD_EN
  logic load_fire;
  always_comb begin
    load_ready = ~fetch_en & ~inflight_q & ~redirect_valid;
    load_fire  = load_valid & load_ready & rst_n;
    csb0       = ~(issue | load_fire);
    web0       = ~load_fire;
    addr0      = load_fire ? load_addr : rd_addr;
    din0       = load_fire ? load_data : '0;
  end
`else
  always_comb begin
    csb0  = ~issue;
    web0  = 1'b1;
    addr0 = rd_addr;
    din0  = '0;
  end
`endif

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (redirect_valid),
    .count     (count),
    .empty     (empty),
    .head      (head)
  );

  assign inst_valid = ~empty;
  assign inst       = head.inst[DATA_WIDTH-1:0];
  assign inst_pc    = head.pc;

endmodule
`default_nettype wire

// File: tb/tb_imem_fetch.sv
`default_nettype none
// Scoreboard bench: expected {pc,inst} stream derived from "sequential words from
// the last redirect/reset PC"; directed timing checks plus a randomized phase.
module tb_imem_fetch;
  import imem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_ready = 1'b0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        csb0;
  logic        web0;
  logic [7:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0;
`ifdef IMEM_LOAD_EN
  logic        load_valid = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [31:0] load_data = '0;
  logic        load_ready;
`endif

  int vectors = 0;
  int miscompares = 0;
  int pops = 0;

  logic [31:0]  mem [256];
  logic [31:0]  golden [5] = '{32'h003100b3, 32'h40730233, 32'h029301b3,
                                32'h003103b3, 32'h00610433};
  fetch_entry_t exp_q [$];
  logic [31:0]  exp_pc = 32'h0;
  logic         stall_prev = 1'b0;
  logic [63:0]  head_prev = '0;

  always #5 clk = ~clk;

  imem_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
`ifdef IMEM_LOAD_EN
    .load_valid     (load_valid),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .load_ready     (load_ready),
`endif
    .csb0           (csb0),
    .web0           (web0),
    .addr0          (addr0),
    .din0           (din0),
    .dout0          (dout0)
  );

  // SRAM model: inputs sampled at the edge, read data valid until the next edge.
  always @(posedge clk) begin
    if (!csb0 && !web0) begin
      mem[addr0] <= din0;
      dout0      <= 'x;
    end else if (!csb0) begin
      dout0 <= mem[addr0];
    end else begin
      dout0 <= 'x;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    fetch_entry_t e;
    if (!rst_n) begin
      exp_q.delete();
      exp_pc = 32'h0;
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && !redirect_valid) begin
        check("head_stable", {inst_valid, inst_pc, inst}, {1'b1, head_prev});
      end
      if (inst_valid && inst_ready && !redirect_valid) begin
        e = exp_q.pop_front();
        check("stream", {inst_pc, inst}, e);
        pops++;
      end
      if (redirect_valid) begin
        check("redirect_blocks_issue", csb0, 1'b1);
        exp_q.delete();
        exp_pc = redirect_pc & ~32'h3;
      end
      if (!fetch_en) begin
        check("no_read_when_disabled", !csb0 && web0, 1'b0);
      end
      stall_prev = inst_valid && !inst_ready && !redirect_valid;
      head_prev  = {inst_pc, inst};
    end
    while (exp_q.size() < 8) begin
      e.pc   = exp_pc;
      e.inst = mem[exp_pc[9:2]];
      exp_q.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
  end

  task automatic drive_next();
    @(posedge clk);
    #1;
  endtask

  task automatic do_redirect(input logic [31:0] pc);
    drive_next();
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    check("redirect_cycle_csb0", csb0, 1'b1);
    drive_next();
    redirect_valid = 1'b0;
  endtask

  initial begin
    logic        found;
    logic [31:0] w255;
    int          web_low;
    int          pops_start;

    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int i = 0; i < 5; i++) mem[i] = golden[i];
    w255 = mem[255];

    // Reset state.
    repeat (2) @(posedge clk);
    fetch_en = 1'b1;
    @(negedge clk);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_head", {inst_pc, inst}, 64'h0);
    check("rst_sram", {csb0, web0, addr0, din0}, {1'b1, 1'b1, 8'h00, 32'h0});

    // Streaming from RESET_PC.
    drive_next();
    rst_n = 1'b1;
    inst_ready = 1'b1;
    @(negedge clk);
    check("first_issue", {csb0, addr0}, {1'b0, 8'h00});
    @(negedge clk);
    check("latency_not_yet_valid", inst_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stream_directed", {inst_valid, inst_pc, inst}, {1'b1, 32'(4 * i), golden[i]});
    end

    // Backpressure.
    do_redirect(32'h0);
    @(negedge clk);
    @(negedge clk);
    check("bp_not_yet_valid", inst_valid, 1'b0);
    drive_next();
    inst_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_head_hold", {inst_valid, inst_pc, inst}, {1'b1, 32'h0, golden[0]});
      check("bp_no_issue", csb0, 1'b1);
    end
    drive_next();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_release_order", {inst_valid, inst_pc}, {1'b1, 32'(4 * i)});
    end

    // Redirect squashing the read of pc=8.
    do_redirect(32'h0);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!csb0 && addr0 == 8'd2) found = 1'b1;
    end
    check("pc8_issue_seen", found, 1'b1);
    do_redirect(32'hC);
    @(negedge clk);
    check("post_redirect_issue", {csb0, addr0}, {1'b0, 8'h03});
    @(negedge clk);
    check("squashed_not_valid", inst_valid, 1'b0);
    @(negedge clk);
    check("post_redirect_head", {inst_valid, inst_pc, inst}, {1'b1, 32'hC, golden[3]});

    // Address wrap.
    do_redirect(32'h3FC);
    @(negedge clk);
    check("wrap_addr_ff", {csb0, addr0}, {1'b0, 8'hFF});
    @(negedge clk);
    check("wrap_addr_00", {csb0, addr0}, {1'b0, 8'h00});
    @(negedge clk);
    check("wrap_head_3fc", {inst_valid, inst_pc, inst}, {1'b1, 32'h3FC, w255});
    @(negedge clk);
    check("wrap_head_400", {inst_valid, inst_pc, inst}, {1'b1, 32'h400, golden[0]});

    // Reset in the middle of a read.
    @(negedge clk);
    check("pre_reset_reading", csb0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_outputs", {csb0, web0, inst_valid, addr0}, {1'b1, 1'b1, 1'b0, 8'h00});
    check("midrst_head", {inst_pc, inst}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_restart_issue", {csb0, addr0}, {1'b0, 8'h00});
    @(negedge clk);
    @(negedge clk);
    check("rst_restart_head", {inst_valid, inst_pc, inst}, {1'b1, 32'h0, golden[0]});

`ifdef IMEM_LOAD_EN
    // Write port, then fetch the written word.
    drive_next();
    fetch_en = 1'b0;
    repeat (3) drive_next();
    load_valid = 1'b1;
    load_addr  = 8'd5;
    load_data  = 32'hDEADBEEF;
    @(negedge clk);
    check("load_ready", load_ready, 1'b1);
    check("load_write", {csb0, web0, addr0, din0}, {1'b0, 1'b0, 8'd5, 32'hDEADBEEF});
    web_low = 1;
    drive_next();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!web0) web_low++;
    end
    check("load_one_cycle", 64'(web_low), 64'd1);
    drive_next();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h14;
    fetch_en       = 1'b1;
    drive_next();
    redirect_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check("load_fetch_back", {inst_valid, inst_pc, inst}, {1'b1, 32'h14, 32'hDEADBEEF});
`endif

    // Randomized traffic.
    pops_start = pops;
    for (int i = 0; i < 1500; i++) begin
      drive_next();
      fetch_en       = ($urandom % 8) != 0;
      inst_ready     = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 32) == 0;
      redirect_pc    = $urandom;
    end
    drive_next();
    redirect_valid = 1'b0;
    repeat (5) @(posedge clk);
    check("random_progress", 64'(pops - pops_start >= 200), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
